// File: rtl/lt24_pkg.sv
// Shared constants and state encoding for the LT24 pixel sink.
package lt24_pkg;

  localparam logic [7:0] CMD_COLSET  = 8'h2A;
  localparam logic [7:0] CMD_PAGESET = 8'h2B;
  localparam logic [7:0] CMD_MEMWR   = 8'h2C;

  typedef enum logic [2:0] {
    IDLE,
    CMD_COL,
    DAT_COL,
    CMD_PAGE,
    DAT_PAGE,
    CMD_MEMW,
    PIXEL
  } state_t;

endpackage

// File: rtl/lt24_bus_write.sv
// Single 8080-style write strobe: low phase, then high phase.
module lt24_bus_write
  import lt24_pkg::*;
#(
  parameter int WR_LOW_CYCLES  = 2,
  parameter int WR_HIGH_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        rs,
  input  logic [15:0] data,
  output logic        wr_n,
  output logic        busy,
  output logic        done,
  output logic        bus_rs,
  output logic [15:0] bus_data
);

  localparam int TOTAL = WR_LOW_CYCLES + WR_HIGH_CYCLES;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);
  localparam logic [CW-1:0] LOW  = CW'(WR_LOW_CYCLES);

  logic          active;
  logic [CW-1:0] cnt;

  // RS and data are latched at start so they hold for the whole strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      active   <= 1'b0;
      cnt      <= '0;
      bus_rs   <= 1'b1;
      bus_data <= '0;
    end else if (start) begin
      active   <= 1'b1;
      cnt      <= '0;
      bus_rs   <= rs;
      bus_data <= data;
    end else if (active) begin
      if (cnt == LAST)
        active <= 1'b0;
      else
        cnt <= cnt + 1'b1;
    end
  end

  assign wr_n = !(active && (cnt < LOW));
  assign busy = active;
  assign done = active && (cnt == LAST);

endmodule

// File: rtl/lt24_pixel_sink.sv
// Pixel-write responder driving LT24 column/page/memwrite cycles.
module lt24_pixel_sink
  import lt24_pkg::*;
#(
  parameter int WIDTH          = 240,
  parameter int HEIGHT         = 320,
  parameter int WR_LOW_CYCLES  = 2,
  parameter int WR_HIGH_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sinkEnable,
  input  logic [7:0]  xAddr,
  input  logic [8:0]  yAddr,
  input  logic [15:0] pixelData,
  input  logic        pixelWrite,
  output logic        pixelReady,
  output logic        LT24CS_n,
  output logic        LT24RS,
  output logic        LT24Wr_n,
  output logic        LT24Rd_n,
  output logic [15:0] LT24Data
);

  localparam logic [15:0] COL_END  = 16'(WIDTH - 1);
  localparam logic [15:0] PAGE_END = 16'(HEIGHT - 1);
  localparam logic [7:0]  X_LAST   = 8'(WIDTH - 1);
  localparam logic [8:0]  Y_LAST   = 9'(HEIGHT - 1);

  state_t      state, state_n;
  logic [1:0]  idx, idx_n;
  logic [7:0]  x_q, x_n;
  logic [8:0]  y_q, y_n;
  logic [15:0] d_q, d_n;
  logic [7:0]  pred_x, col_start;
  logic [8:0]  pred_y;
  logic        pred_valid;
  logic        accept, stream, start;
  logic        done, busy;
  logic        wr_rs;
  logic [15:0] wr_data;

  assign accept = pixelWrite && pixelReady;
  assign stream = pred_valid && (xAddr == pred_x)
               && (yAddr == pred_y);
  assign x_n = accept ? xAddr : x_q;
  assign y_n = accept ? yAddr : y_q;
  assign d_n = accept ? pixelData : d_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    unique case (state)
      IDLE:
        if (accept) state_n = stream ? PIXEL : CMD_COL;
      CMD_COL:
        if (done) state_n = DAT_COL;
      DAT_COL:
        if (done) begin
          idx_n = idx + 1'b1;
          if (idx == 2'd3) state_n = CMD_PAGE;
        end
      CMD_PAGE:
        if (done) state_n = DAT_PAGE;
      DAT_PAGE:
        if (done) begin
          idx_n = idx + 1'b1;
          if (idx == 2'd3) state_n = CMD_MEMW;
        end
      CMD_MEMW:
        if (done) state_n = PIXEL;
      PIXEL:
        if (done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // The word for the upcoming write is chosen from the next state.
  always_comb begin
    pixelReady = (state == IDLE) && !busy
              && sinkEnable && !reset;
    start   = accept || (done && state != PIXEL);
    wr_rs   = 1'b1;
    wr_data = '0;
    unique case (state_n)
      CMD_COL: begin
        wr_rs   = 1'b0;
        wr_data = {8'h00, CMD_COLSET};
      end
      DAT_COL:
        unique case (idx_n)
          2'd0: wr_data = 16'h0000;
          2'd1: wr_data = {8'h00, x_n};
          2'd2: wr_data = {8'h00, COL_END[15:8]};
          default: wr_data = {8'h00, COL_END[7:0]};
        endcase
      CMD_PAGE: begin
        wr_rs   = 1'b0;
        wr_data = {8'h00, CMD_PAGESET};
      end
      DAT_PAGE:
        unique case (idx_n)
          2'd0: wr_data = {15'h0000, y_n[8]};
          2'd1: wr_data = {8'h00, y_n[7:0]};
          2'd2: wr_data = {8'h00, PAGE_END[15:8]};
          default: wr_data = {8'h00, PAGE_END[7:0]};
        endcase
      CMD_MEMW: begin
        wr_rs   = 1'b0;
        wr_data = {8'h00, CMD_MEMWR};
      end
      PIXEL:   wr_data = d_n;
      default: wr_data = '0;
    endcase
  end

  // Mirror of the controller's auto-increment pointer.
  always_ff @(posedge clock) begin
    if (reset) begin
      pred_valid <= 1'b0;
      pred_x     <= '0;
      pred_y     <= '0;
      col_start  <= '0;
      x_q        <= '0;
      y_q        <= '0;
      d_q        <= '0;
    end else begin
      if (accept) begin
        x_q <= xAddr;
        y_q <= yAddr;
        d_q <= pixelData;
        if (!stream) col_start <= xAddr;
      end
      if (state == PIXEL && done) begin
        if (x_q < X_LAST) begin
          pred_x     <= x_q + 1'b1;
          pred_y     <= y_q;
          pred_valid <= 1'b1;
        end else if (y_q < Y_LAST) begin
          pred_x     <= col_start;
          pred_y     <= y_q + 1'b1;
          pred_valid <= 1'b1;
        end else begin
          pred_valid <= 1'b0;
        end
      end else if (state == IDLE && !sinkEnable) begin
        pred_valid <= 1'b0;
      end
    end
  end

  lt24_bus_write #(
    .WR_LOW_CYCLES  (WR_LOW_CYCLES),
    .WR_HIGH_CYCLES (WR_HIGH_CYCLES)
  ) u_wr (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .rs       (wr_rs),
    .data     (wr_data),
    .wr_n     (LT24Wr_n),
    .busy     (busy),
    .done     (done),
    .bus_rs   (LT24RS),
    .bus_data (LT24Data)
  );

  assign LT24CS_n = (state == IDLE);
  assign LT24Rd_n = 1'b1;

endmodule

// File: tb/tb_lt24_pixel_sink.sv
// Scoreboard bench: model predicts bus writes, monitor checks Wr_n rises.
module tb_lt24_pixel_sink;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sinkEnable = 1'b1;
  logic [7:0]  xAddr = '0;
  logic [8:0]  yAddr = '0;
  logic [15:0] pixelData = '0;
  logic        pixelWrite = 1'b0;
  logic        pixelReady;
  logic        LT24CS_n, LT24RS, LT24Wr_n, LT24Rd_n;
  logic [15:0] LT24Data;

  always #5 clock = ~clock;

  lt24_pixel_sink dut (
    .clock      (clock),
    .reset      (reset),
    .sinkEnable (sinkEnable),
    .xAddr      (xAddr),
    .yAddr      (yAddr),
    .pixelData  (pixelData),
    .pixelWrite (pixelWrite),
    .pixelReady (pixelReady),
    .LT24CS_n   (LT24CS_n),
    .LT24RS     (LT24RS),
    .LT24Wr_n   (LT24Wr_n),
    .LT24Rd_n   (LT24Rd_n),
    .LT24Data   (LT24Data)
  );

  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q[$];
  logic prev_wr = 1'b1;

  // Reference model of the display's address pointer.
  bit m_pv = 0;
  int m_px = 0;
  int m_py = 0;
  int m_col = 0;

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic void push(bit rs, int v);
    exp_q.push_back({rs, 16'(v)});
  endfunction

  function automatic int model_issue(int x, int y, int d);
    bit full;
    full = !(m_pv && x == m_px && y == m_py);
    if (full) begin
      push(0, 'h2A);
      push(1, 0);
      push(1, x);
      push(1, (240 - 1) / 256);
      push(1, (240 - 1) % 256);
      push(0, 'h2B);
      push(1, y / 256);
      push(1, y % 256);
      push(1, (320 - 1) / 256);
      push(1, (320 - 1) % 256);
      push(0, 'h2C);
      m_col = x;
    end
    push(1, d);
    if (x < 239) begin
      m_px = x + 1;
      m_py = y;
      m_pv = 1;
    end else if (y < 319) begin
      m_px = m_col;
      m_py = y + 1;
      m_pv = 1;
    end else begin
      m_pv = 0;
    end
    return full ? 48 : 4;
  endfunction

  always @(negedge clock) begin : monitor
    logic [16:0] e;
    if (!prev_wr && LT24Wr_n) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL bus_write: unexpected rs=%b data=%h",
                 LT24RS, LT24Data);
      end else begin
        e = exp_q.pop_front();
        check("bus_write cs/rs/data",
              {15'd0, LT24CS_n, LT24RS, LT24Data},
              {15'd0, 1'b0, e});
      end
    end
    prev_wr <= LT24Wr_n;
  end

  task automatic wait_ready(output bit ok);
    int n;
    n = 0;
    ok = 1;
    forever begin
      @(negedge clock);
      if (pixelReady) break;
      n++;
      if (n > 500) begin
        checks++;
        errors++;
        $display("FAIL wait_ready: timeout");
        ok = 0;
        break;
      end
    end
  endtask

  task automatic send_pixel(int x, int y, int d, string name);
    int lat;
    int n;
    bit ok;
    @(posedge clock);
    #1;
    xAddr = 8'(x);
    yAddr = 9'(y);
    pixelData = 16'(d);
    pixelWrite = 1'b1;
    wait_ready(ok);
    if (!ok) begin
      pixelWrite = 1'b0;
      return;
    end
    lat = model_issue(x, y, d);
    @(posedge clock);
    #1;
    pixelWrite = 1'b0;
    n = 0;
    forever begin
      @(negedge clock);
      if (pixelReady || n > 500) break;
      n++;
    end
    check({name, " busy clocks"}, n, lat);
    check({name, " writes left"}, exp_q.size(), 0);
  endtask

  initial begin
    int x, y, r;
    bit ok;

    repeat (3) begin
      @(negedge clock);
      check("reset outputs",
            {pixelReady, LT24CS_n, LT24Wr_n, LT24Rd_n,
             LT24RS, LT24Data},
            {1'b0, 4'b1111, 16'h0000});
    end
    @(posedge clock);
    #1 reset = 1'b0;
    repeat (5) begin
      @(negedge clock);
      check("idle outputs",
            {pixelReady, LT24CS_n, LT24Wr_n, LT24Rd_n},
            4'b1111);
    end

    send_pixel(0, 0, 'h5FE8, "first full");
    send_pixel(1, 0, 'hFA28, "first stream");
    for (int i = 2; i < 240; i++)
      send_pixel(i, 0, $urandom_range(0, 65535), "row");
    send_pixel(0, 1, 'h1234, "row wrap");

    send_pixel(3, 5, 'h0F0F, "pre jump");
    send_pixel(10, 5, 'hA5A5, "jump");

    send_pixel(239, 319, 'hFFFF, "frame end");
    send_pixel(0, 0, 'h0001, "after frame");

    // Reset while the page data bytes are on the bus.
    @(posedge clock);
    #1;
    xAddr = 8'd20;
    yAddr = 9'd30;
    pixelData = 16'hBEEF;
    pixelWrite = 1'b1;
    wait_ready(ok);
    if (ok) begin
      void'(model_issue(20, 30, 'hBEEF));
      @(posedge clock);
      #1 pixelWrite = 1'b0;
      repeat (34) @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      check("reset mid write",
            {LT24Wr_n, LT24CS_n, pixelReady}, 3'b110);
      check("abandoned writes", exp_q.size(), 3);
    end
    pixelWrite = 1'b0;
    exp_q.delete();
    m_pv = 0;
    @(posedge clock);
    #1 reset = 1'b0;
    send_pixel(21, 30, 'h4321, "after reset");

    // Disabled sink ignores a waiting writer.
    @(posedge clock);
    #1;
    sinkEnable = 1'b0;
    xAddr = 8'd22;
    yAddr = 9'd30;
    pixelWrite = 1'b1;
    repeat (8) begin
      @(negedge clock);
      check("disabled",
            {pixelReady, LT24Wr_n, LT24CS_n}, 3'b011);
    end
    @(posedge clock);
    #1;
    pixelWrite = 1'b0;
    sinkEnable = 1'b1;
    m_pv = 0;
    send_pixel(22, 30, 'h7777, "after disable");

    send_pixel(5, 7, 'h1111, "pre toggle");
    @(posedge clock);
    #1 sinkEnable = 1'b0;
    @(posedge clock);
    #1 sinkEnable = 1'b1;
    m_pv = 0;
    send_pixel(6, 7, 'h2222, "after toggle");

    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      if (r == 9) begin
        @(posedge clock);
        #1 sinkEnable = 1'b0;
        @(posedge clock);
        #1 sinkEnable = 1'b1;
        m_pv = 0;
      end
      if (r < 7 && m_pv) begin
        x = m_px;
        y = m_py;
      end else begin
        x = $urandom_range(0, 255);
        y = $urandom_range(0, 319);
      end
      send_pixel(x, y, $urandom_range(0, 65535), "random");
    end

    repeat (10) @(negedge clock);
    check("final queue empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
